// File: rtl/jp_pkg.sv
// Shared joypad definitions used by the controller-port responder and the
// rp2a03 joypad logic.
// Contents:
//   BTN_A..BTN_RIGHT  bit index of each button in every 8-bit button vector
//   btn_t             packed view of a button vector; field a sits at bit 0
//   turbo_mask()      applies turbo gating to the A/B buttons
package jp_pkg;

  localparam int NUM_BTNS  = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // The first field is the MSB, so a lands on bit 0, matching BTN_A.
  typedef struct packed {
    logic right;
    logic left;
    logic down;
    logic up;
    logic start;
    logic select;
    logic b;
    logic a;
  } btn_t;

  // A turbo-enabled button only reads as pressed while the phase is high.
  function automatic btn_t turbo_mask(btn_t btn, logic [1:0] en, logic phase);
    btn_t m;
    m = btn;
    if (en[0]) m.a = btn.a & phase;
    if (en[1]) m.b = btn.b & phase;
    return m;
  endfunction

endpackage

// File: rtl/jp_debounce.sv
// Single-bit debouncer. The output follows the input only after the input
// has disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any cycle of
// agreement restarts the count.
// Ports:
//   clk_in     system clock
//   rst_in     synchronous active-high reset
//   level_in   synchronized level, active-high
//   level_out  debounced level, active-high, resets to 0
module jp_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic level_in,
  output logic level_out
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt       <= '0;
      level_out <= 1'b0;
    end else if (level_in == level_out) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt       <= '0;
      level_out <= level_in;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jp_responder.sv
// Console controller-port responder: emulates a 4021-style parallel-in /
// serial-out shift register fed by debounced board buttons, with optional
// turbo on A and B.
// Ports:
//   clk_in        system clock (clk_25 domain)
//   rst_in        synchronous active-high reset
//   jp_latch_in   console latch, active-high, asynchronous
//   jp_clk_in     console shift clock, rising edge shifts, asynchronous
//   buttons_n_in  raw buttons, active-low, bit order per jp_pkg
//   turbo_en_in   [0] turbo on A, [1] turbo on B
//   jp_data_out   serial data to console, active-low
//   buttons_out   debounced buttons, active-high
module jp_responder
  import jp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TURBO_LATCHES   = 4
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                jp_latch_in,
  input  logic                jp_clk_in,
  input  logic [NUM_BTNS-1:0] buttons_n_in,
  input  logic [1:0]          turbo_en_in,
  output logic                jp_data_out,
  output logic [NUM_BTNS-1:0] buttons_out
);

  localparam int TW_RAW = $clog2(TURBO_LATCHES + 1);
  localparam int TW     = (TW_RAW > 3) ? TW_RAW : 3;
  localparam logic [TW-1:0] TURBO_LAST = TW'(TURBO_LATCHES - 1);

  // Console pins: 2-flop synchronizer plus one delayed copy for edges.
  logic [1:0] latch_sync, jclk_sync;
  logic       latch_q, jclk_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      latch_sync <= '0;
      jclk_sync  <= '0;
      latch_q    <= 1'b0;
      jclk_q     <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[0], jp_latch_in};
      jclk_sync  <= {jclk_sync[0], jp_clk_in};
      latch_q    <= latch_sync[1];
      jclk_q     <= jclk_sync[1];
    end
  end

  logic latch_lvl, latch_fall, jclk_rise;
  assign latch_lvl  = latch_sync[1];
  assign latch_fall = latch_q & ~latch_sync[1];
  assign jclk_rise  = jclk_sync[1] & ~jclk_q;

  // Button synchronizers idle at 1 (released) so reset does not look
  // like a press.
  logic [NUM_BTNS-1:0] btn_s1, btn_s2;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      btn_s1 <= '1;
      btn_s2 <= '1;
    end else begin
      btn_s1 <= buttons_n_in;
      btn_s2 <= btn_s1;
    end
  end

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_db
    jp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .level_in  (~btn_s2[g]),
      .level_out (buttons_out[g])
    );
  end

  // Turbo phase flips once every TURBO_LATCHES latch falling edges. The
  // counter runs regardless of turbo_en_in so enabling turbo mid-game
  // keeps a steady cadence.
  logic [TW-1:0] turbo_cnt;
  logic          turbo_phase;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b1;
    end else if (latch_fall) begin
      if (turbo_cnt == TURBO_LAST) begin
        turbo_cnt   <= '0;
        turbo_phase <= ~turbo_phase;
      end else begin
        turbo_cnt <= turbo_cnt + 1'b1;
      end
    end
  end

  btn_t load_val;
  assign load_val = turbo_mask(btn_t'(buttons_out), turbo_en_in, turbo_phase);

  // Shift register: latch wins over a coincident shift edge. Ones are
  // shifted in, so after eight shifts the line reads pressed (0) as on
  // the original part.
  logic [NUM_BTNS-1:0] shreg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shreg       <= '0;
      jp_data_out <= 1'b1;
    end else begin
      if (latch_lvl)
        shreg <= load_val;
      else if (jclk_rise)
        shreg <= {1'b1, shreg[NUM_BTNS-1:1]};
      jp_data_out <= ~shreg[0];
    end
  end

endmodule
